// File: rtl/fetch_if.sv
// Fetch-side bus: instruction memory port, execute-stage redirect and the
// valid/ready instruction handoff to decode.
interface fetch_if #(
  parameter int Nbits = 32
);
  logic [63:0]      imem_addr;
  logic [Nbits-1:0] imem_instr;
  logic             redirect_valid;
  logic [63:0]      redirect_pc;
  logic             instr_ready;
  logic             instr_valid;
  logic [Nbits-1:0] instr_out;
  logic [63:0]      pc_out;
  logic             misalign_fault;
  logic [31:0]      fetch_count;

  modport master (
    output imem_addr, instr_valid, instr_out, pc_out, misalign_fault, fetch_count,
    input  imem_instr, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_addr, instr_valid, instr_out, pc_out, misalign_fault, fetch_count,
    output imem_instr, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Program counter owner for the multicycle core: fetches one word per PC,
// holds it for decode, and follows execute-stage redirects.
module fetch_unit #(
  parameter int          Nbits    = 32,
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {FETCH, HOLD, FAULT} state_t;

  state_t           state, state_nxt;
  logic [63:0]      pc, pc_nxt;
  logic [Nbits-1:0] instr_p0, instr_nxt;
  logic [63:0]      pc_p0, pc_p0_nxt;
  logic             vld_p0, vld_nxt;
  logic             fault, fault_nxt;
  logic [31:0]      count, count_nxt;
  logic             target_misaligned;

  assign target_misaligned = (bus.redirect_pc[1:0] != 2'b00);

  // Redirect outranks both the capture in FETCH and the handshake in HOLD.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr_p0;
    pc_p0_nxt = pc_p0;
    vld_nxt   = vld_p0;
    fault_nxt = fault;
    count_nxt = count;
    case (state)
      FETCH: begin
        if (bus.redirect_valid) begin
          pc_nxt    = bus.redirect_pc;
          vld_nxt   = 1'b0;
          if (target_misaligned) begin
            fault_nxt = 1'b1;
            state_nxt = FAULT;
          end else begin
            state_nxt = FETCH;
          end
        end else begin
          instr_nxt = bus.imem_instr;
          pc_p0_nxt = pc;
          vld_nxt   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          pc_nxt    = bus.redirect_pc;
          vld_nxt   = 1'b0;
          if (target_misaligned) begin
            fault_nxt = 1'b1;
            state_nxt = FAULT;
          end else begin
            state_nxt = FETCH;
          end
        end else if (vld_p0 && bus.instr_ready) begin
          pc_nxt    = pc + 64'(PC_STEP);
          vld_nxt   = 1'b0;
          count_nxt = count + 32'd1;
          state_nxt = FETCH;
        end
      end
      FAULT: begin
        vld_nxt   = 1'b0;
        fault_nxt = 1'b1;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      instr_p0 <= '0;
      pc_p0    <= '0;
      vld_p0   <= 1'b0;
      fault    <= 1'b0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      instr_p0 <= instr_nxt;
      pc_p0    <= pc_p0_nxt;
      vld_p0   <= vld_nxt;
      fault    <= fault_nxt;
      count    <= count_nxt;
    end
  end

  assign bus.imem_addr      = pc;
  assign bus.instr_valid    = vld_p0;
  assign bus.instr_out      = instr_p0;
  assign bus.pc_out         = pc_p0;
  assign bus.misalign_fault = fault;
  assign bus.fetch_count    = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance from address 0, one starting
// just below 2^64 to exercise PC wrap and mid-cycle reset.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fetch_if #(.Nbits(32)) bus_a ();
  fetch_if #(.Nbits(32)) bus_b ();

  fetch_unit #(.Nbits(32), .RESET_PC(64'h0), .PC_STEP(4)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  fetch_unit #(.Nbits(32), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .PC_STEP(4)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  function automatic logic [31:0] imem_word(input logic [63:0] addr);
    if (addr == 64'h0) return 32'h0050_0093;
    return 32'h1000_0000 | addr[31:0];
  endfunction

  always_comb bus_a.imem_instr = imem_word(bus_a.imem_addr);
  always_comb bus_b.imem_instr = imem_word(bus_b.imem_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] held_instr;
    logic [63:0] held_pc;

    bus_a.redirect_valid = 1'b0;
    bus_a.redirect_pc    = 64'h0;
    bus_a.instr_ready    = 1'b0;
    bus_b.redirect_valid = 1'b0;
    bus_b.redirect_pc    = 64'h0;
    bus_b.instr_ready    = 1'b0;

    // Reset held for three cycles, then first fetch
    repeat (3) @(negedge clk);
    check("rst_valid", bus_a.instr_valid, 1'b0);
    check("rst_addr", bus_a.imem_addr, 64'h0);
    check("rst_count", bus_a.fetch_count, 32'd0);
    check("rst_pc_out", bus_a.pc_out, 64'h0);
    check("rst_fault", bus_a.misalign_fault, 1'b0);
    rst_a = 1'b1;
    @(negedge clk);
    check("first_valid", bus_a.instr_valid, 1'b1);
    check("first_instr", bus_a.instr_out, 32'h0050_0093);
    check("first_pc", bus_a.pc_out, 64'h0);

    // Backpressure: five cycles of instr_ready=0
    held_instr = 32'h0050_0093;
    held_pc    = 64'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", bus_a.instr_valid, 1'b1);
      check("bp_instr", bus_a.instr_out, held_instr);
      check("bp_pc", bus_a.pc_out, held_pc);
    end
    bus_a.instr_ready = 1'b1;
    @(negedge clk);
    bus_a.instr_ready = 1'b0;
    check("acc_valid", bus_a.instr_valid, 1'b0);
    check("acc_addr", bus_a.imem_addr, 64'h4);
    check("acc_count", bus_a.fetch_count, 32'd1);
    @(negedge clk);
    check("acc_next_valid", bus_a.instr_valid, 1'b1);
    check("acc_next_pc", bus_a.pc_out, 64'h4);
    check("acc_next_instr", bus_a.instr_out, 32'h1000_0004);

    // Streaming from a fresh reset, ready tied high for eight accepts
    rst_a = 1'b0;
    #1;
    check("rst2_valid", bus_a.instr_valid, 1'b0);
    check("rst2_count", bus_a.fetch_count, 32'd0);
    rst_a = 1'b1;
    bus_a.instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("str_valid_hi", bus_a.instr_valid, 1'b1);
      check("str_pc", bus_a.pc_out, 64'(4 * i));
      @(negedge clk);
      check("str_valid_lo", bus_a.instr_valid, 1'b0);
    end
    bus_a.instr_ready = 1'b0;
    check("str_count", bus_a.fetch_count, 32'd8);
    check("str_addr", bus_a.imem_addr, 64'h20);

    // Aligned redirect while in FETCH: no instruction from the old PC
    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_pc    = 64'h8;
    @(negedge clk);
    bus_a.redirect_valid = 1'b0;
    check("rdf_valid", bus_a.instr_valid, 1'b0);
    check("rdf_addr", bus_a.imem_addr, 64'h8);
    check("rdf_count", bus_a.fetch_count, 32'd8);
    @(negedge clk);
    check("rdf_pc_out", bus_a.pc_out, 64'h8);
    check("rdf_instr", bus_a.instr_out, 32'h1000_0008);

    // Redirect colliding with an accept in HOLD
    bus_a.instr_ready    = 1'b1;
    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_pc    = 64'h40;
    @(negedge clk);
    bus_a.instr_ready    = 1'b0;
    bus_a.redirect_valid = 1'b0;
    check("col_count", bus_a.fetch_count, 32'd8);
    check("col_addr", bus_a.imem_addr, 64'h40);
    check("col_valid", bus_a.instr_valid, 1'b0);
    @(negedge clk);
    check("col_pc_out", bus_a.pc_out, 64'h40);
    check("col_instr", bus_a.instr_out, 32'h1000_0040);

    // Misaligned redirect locks the unit until reset
    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_pc    = 64'h22;
    @(negedge clk);
    check("mis_fault", bus_a.misalign_fault, 1'b1);
    check("mis_valid", bus_a.instr_valid, 1'b0);
    check("mis_addr", bus_a.imem_addr, 64'h22);
    bus_a.redirect_pc = 64'h10;
    bus_a.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flt_valid", bus_a.instr_valid, 1'b0);
      check("flt_addr", bus_a.imem_addr, 64'h22);
      check("flt_fault", bus_a.misalign_fault, 1'b1);
      check("flt_count", bus_a.fetch_count, 32'd8);
    end
    rst_a = 1'b0;
    #1;
    check("clr_fault", bus_a.misalign_fault, 1'b0);
    check("clr_addr", bus_a.imem_addr, 64'h0);
    check("clr_count", bus_a.fetch_count, 32'd0);
    bus_a.redirect_valid = 1'b0;
    bus_a.instr_ready    = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;

    // PC wrap from the top of the address space, then reset between edges
    rst_b = 1'b1;
    @(negedge clk);
    check("wrap_valid", bus_b.instr_valid, 1'b1);
    check("wrap_pc", bus_b.pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_instr", bus_b.instr_out, 32'hFFFF_FFFC);
    bus_b.instr_ready = 1'b1;
    @(negedge clk);
    bus_b.instr_ready = 1'b0;
    check("wrap_addr", bus_b.imem_addr, 64'h0);
    check("wrap_count", bus_b.fetch_count, 32'd1);
    @(negedge clk);
    check("wrap_hold_valid", bus_b.instr_valid, 1'b1);
    check("wrap_hold_pc", bus_b.pc_out, 64'h0);
    #2;
    rst_b = 1'b0;
    #1;
    check("async_valid", bus_b.instr_valid, 1'b0);
    check("async_pc_out", bus_b.pc_out, 64'h0);
    check("async_addr", bus_b.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("async_count", bus_b.fetch_count, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
